// File: rtl/jtdd2_sndcmd.sv
// jtdd2_sndcmd: main-CPU side transmitter for the sound command interface.
// Command bytes written by the main CPU are queued in a 2**AW entry FIFO and
// handed to the sound CPU one at a time: each byte is placed on snd_latch with
// an IRQ_LEN cycle snd_irq pulse, and the next byte waits for the sound CPU to
// read the latch (rising edge of snd_ack). The block also owns the sound CPU
// reset line, whose assertion flushes any queued commands.
// Build macro SNDCMD_TIMEOUT_EN: when defined, a command whose latch read never
// arrives within TO_LEN cycles is abandoned and the event is flagged on overflow.

module jtdd2_sndcmd #(
    parameter int AW      = 2,
    parameter int IRQ_LEN = 8,
    parameter int TO_LEN  = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       snd_wr,
    input  logic [7:0] cpu_dout,
    input  logic       rstb_wr,
    input  logic       rstb_din,
    input  logic       snd_ack,
    output logic [7:0] snd_latch,
    output logic       snd_irq,
    output logic       snd_rstb,
    output logic       busy,
    output logic       full,
    output logic       overflow
);

    localparam int          DEPTH    = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [7:0]  IRQ_LAST = 8'(IRQ_LEN - 1);

    // Elaboration-time guard on the parameter ranges the counters are sized for
    if (AW < 1 || IRQ_LEN < 1 || IRQ_LEN > 255 || TO_LEN < 1 || TO_LEN > 65535) begin : g_bad_param
        $error("jtdd2_sndcmd: parameter out of range");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    fifo_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [7:0]    latch_q, latch_d;
    logic [7:0]    pcnt_q, pcnt_d;
    logic          irq_q, irq_d;
    logic          rstb_q, rstb_d;
    logic          busy_q, busy_d;
    logic          full_q, full_d;
    logic          overflow_q, overflow_d;
    logic          ack_seen_q, ack_seen_d;
    logic          ack_dly_q;
    logic          ack_rise;
    logic          flush;
    logic          push;
    logic          drop;
    logic          pop;
    logic          timeout;

    // A reset-control write of 0 wipes the queue; any reset-control write
    // claims the cycle, so a command byte written alongside it is lost.
    assign ack_rise = snd_ack & ~ack_dly_q;
    assign flush    = rstb_wr & ~rstb_din;
    assign push     = snd_wr & ~rstb_wr & (count_q != FULL_CNT);
    assign drop     = snd_wr & ~rstb_wr & (count_q == FULL_CNT);

`ifdef SNDCMD_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TO_LEN - 1);
    logic [15:0] to_cnt_q;

    // Acknowledge watchdog: counts cycles spent in WAIT, held at zero elsewhere
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt_q <= '0;
        end else if (state_q != WAIT || state_d != WAIT) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_q + 16'd1;
        end
    end
`endif

    // Dispatch FSM: present one byte, pulse the IRQ, then wait for the latch read
    always_comb begin
        state_d    = state_q;
        pcnt_d     = pcnt_q;
        ack_seen_d = ack_seen_q;
        irq_d      = irq_q;
        latch_d    = latch_q;
        pop        = 1'b0;
        timeout    = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0 && rstb_q) begin
                    pop        = 1'b1;
                    latch_d    = fifo_q[rd_ptr_q];
                    irq_d      = 1'b1;
                    pcnt_d     = '0;
                    ack_seen_d = 1'b0;
                    state_d    = PULSE;
                end
            end
            PULSE: begin
                if (ack_rise) begin
                    ack_seen_d = 1'b1;
                end
                if (pcnt_q == IRQ_LAST) begin
                    irq_d   = 1'b0;
                    state_d = (ack_seen_q || ack_rise) ? IDLE : WAIT;
                end else begin
                    pcnt_d = pcnt_q + 8'd1;
                end
            end
            WAIT: begin
                if (ack_rise) begin
                    state_d = IDLE;
                end
`ifdef SNDCMD_TIMEOUT_EN
                else if (to_cnt_q == TO_LAST) begin
                    state_d = IDLE;
                    timeout = 1'b1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (flush) begin
            state_d    = IDLE;
            irq_d      = 1'b0;
            pop        = 1'b0;
            pcnt_d     = '0;
            ack_seen_d = 1'b0;
        end
    end

    // FIFO bookkeeping and the status flags derived from the updated count
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
        overflow_d = flush ? 1'b0 : (overflow_q | drop | timeout);
        full_d     = (count_d == FULL_CNT);
        busy_d     = (state_q != IDLE) || (state_d != IDLE) || (count_d != '0);
        rstb_d     = rstb_wr ? rstb_din : rstb_q;
    end

    // FIFO storage; written only on an accepted push, so no reset is needed
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= cpu_dout;
        end
    end

    // State, counters, pointers and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            latch_q    <= '0;
            pcnt_q     <= '0;
            irq_q      <= 1'b0;
            rstb_q     <= 1'b0;
            busy_q     <= 1'b0;
            full_q     <= 1'b0;
            overflow_q <= 1'b0;
            ack_seen_q <= 1'b0;
            ack_dly_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            latch_q    <= latch_d;
            pcnt_q     <= pcnt_d;
            irq_q      <= irq_d;
            rstb_q     <= rstb_d;
            busy_q     <= busy_d;
            full_q     <= full_d;
            overflow_q <= overflow_d;
            ack_seen_q <= ack_seen_d;
            ack_dly_q  <= snd_ack;
        end
    end

    assign snd_latch = latch_q;
    assign snd_irq   = irq_q;
    assign snd_rstb  = rstb_q;
    assign busy      = busy_q;
    assign full      = full_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_jtdd2_sndcmd.sv
// tb_jtdd2_sndcmd: directed self-checking bench for jtdd2_sndcmd (AW=2,
// IRQ_LEN=8, TO_LEN=16). Build macro SNDCMD_TIMEOUT_EN selects which WAIT
// behaviour the last scenario expects.

module tb_jtdd2_sndcmd;

    logic       clk = 1'b0;
    logic       rst;
    logic       snd_wr;
    logic [7:0] cpu_dout;
    logic       rstb_wr;
    logic       rstb_din;
    logic       snd_ack;
    logic [7:0] snd_latch;
    logic       snd_irq;
    logic       snd_rstb;
    logic       busy;
    logic       full;
    logic       overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    jtdd2_sndcmd #(
        .AW      (2),
        .IRQ_LEN (8),
        .TO_LEN  (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .snd_wr    (snd_wr),
        .cpu_dout  (cpu_dout),
        .rstb_wr   (rstb_wr),
        .rstb_din  (rstb_din),
        .snd_ack   (snd_ack),
        .snd_latch (snd_latch),
        .snd_irq   (snd_irq),
        .snd_rstb  (snd_rstb),
        .busy      (busy),
        .full      (full),
        .overflow  (overflow)
    );

    // 100 MHz bench clock
    always #5 clk = ~clk;

    // Hard stop in case a scenario wedges
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Advance n clocks and settle 1 ns past the last rising edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; snd_wr = 1'b0; cpu_dout = 8'h00; rstb_wr = 1'b0; rstb_din = 1'b0; snd_ack = 1'b0;
        tick(3);
        tests_run++; if (snd_latch !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_latch: got %h expected 00", snd_latch); end
        tests_run++; if (snd_irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_irq: got %b expected 0", snd_irq); end
        tests_run++; if (snd_rstb !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rstb: got %b expected 0", snd_rstb); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        tests_run++; if (full !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_full: got %b expected 0", full); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_overflow: got %b expected 0", overflow); end
        rst = 1'b0;
        tick(2);
        tests_run++; if (snd_rstb !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_rstb_held: got %b expected 0", snd_rstb); end
    endtask

    task automatic test_basic();
        int hi;
        rstb_wr = 1'b1; rstb_din = 1'b1; tick(1); rstb_wr = 1'b0; rstb_din = 1'b0;
        tests_run++; if (snd_rstb !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_rstb_release: got %b expected 1", snd_rstb); end
        cpu_dout = 8'h5a; snd_wr = 1'b1; tick(1); snd_wr = 1'b0; cpu_dout = 8'h00;
        tests_run++; if (snd_irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_irq_n1: got %b expected 0", snd_irq); end
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_busy_n1: got %b expected 1", busy); end
        tick(1);
        tests_run++; if (snd_latch !== 8'h5a) begin tests_failed++; $display("[TB] FAIL basic_latch_n2: got %h expected 5a", snd_latch); end
        tests_run++; if (snd_irq !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_irq_n2: got %b expected 1", snd_irq); end
        hi = 0;
        while (snd_irq === 1'b1 && hi < 50) begin hi++; tick(1); end
        tests_run++; if (hi !== 8) begin tests_failed++; $display("[TB] FAIL basic_irq_width: got %0d expected 8", hi); end
        tick(3);
        tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL basic_busy_wait: got %b expected 1", busy); end
        snd_ack = 1'b1; tick(1); snd_ack = 1'b0; tick(1);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_busy_after_ack: got %b expected 0", busy); end
        tests_run++; if (snd_latch !== 8'h5a) begin tests_failed++; $display("[TB] FAIL basic_latch_kept: got %h expected 5a", snd_latch); end
    endtask

    task automatic test_overflow();
        int n;
        rstb_wr = 1'b1; rstb_din = 1'b0; tick(1); rstb_wr = 1'b0;
        tests_run++; if (snd_rstb !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_rstb_low: got %b expected 0", snd_rstb); end
        for (int i = 1; i <= 5; i++) begin
            cpu_dout = 8'(i); snd_wr = 1'b1; tick(1);
            if (i == 3) begin
                tests_run++; if (full !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_full_at3: got %b expected 0", full); end
            end
            if (i == 4) begin
                tests_run++; if (full !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_full_at4: got %b expected 1", full); end
                tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_early: got %b expected 0", overflow); end
            end
        end
        snd_wr = 1'b0; cpu_dout = 8'h00;
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_set: got %b expected 1", overflow); end
        tests_run++; if (snd_irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_held_in_reset: got %b expected 0", snd_irq); end
        rstb_wr = 1'b1; rstb_din = 1'b1; tick(1); rstb_wr = 1'b0; rstb_din = 1'b0;
        tick(1);
        tests_run++; if (snd_irq !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_first_irq: got %b expected 1", snd_irq); end
        tests_run++; if (snd_latch !== 8'h01) begin tests_failed++; $display("[TB] FAIL ovf_first_latch: got %h expected 01", snd_latch); end
        for (int k = 1; k <= 4; k++) begin
            n = 0;
            while (snd_irq === 1'b1 && n < 20) begin n++; tick(1); end
            tests_run++; if (snd_irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_irq_end_%0d: got %b expected 0", k, snd_irq); end
            snd_ack = 1'b1; tick(1); snd_ack = 1'b0;
            tests_run++; if (snd_irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_m1_irq_%0d: got %b expected 0", k, snd_irq); end
            tick(1);
            if (k < 4) begin
                tests_run++; if (snd_irq !== 1'b1 || snd_latch !== 8'(k + 1)) begin tests_failed++; $display("[TB] FAIL ovf_next_%0d: got irq %b latch %h expected irq 1 latch %h", k, snd_irq, snd_latch, 8'(k + 1)); end
            end else begin
                tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovf_drained_busy: got %b expected 0", busy); end
            end
        end
        tick(20);
        tests_run++; if (snd_irq !== 1'b0 || snd_latch !== 8'h04) begin tests_failed++; $display("[TB] FAIL ovf_no_fifth: got irq %b latch %h expected irq 0 latch 04", snd_irq, snd_latch); end
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_ack_hold();
        int n;
        int rises;
        logic prev;
        for (int i = 0; i < 3; i++) begin
            cpu_dout = 8'hA1 + 8'(i); snd_wr = 1'b1; tick(1);
        end
        snd_wr = 1'b0; cpu_dout = 8'h00;
        n = 0;
        while (snd_irq !== 1'b1 && n < 20) begin n++; tick(1); end
        tests_run++; if (snd_irq !== 1'b1 || snd_latch !== 8'hA1) begin tests_failed++; $display("[TB] FAIL hold_first: got irq %b latch %h expected irq 1 latch a1", snd_irq, snd_latch); end
        n = 0;
        while (snd_irq === 1'b1 && n < 20) begin n++; tick(1); end
        snd_ack = 1'b1;
        rises = 0;
        prev = snd_irq;
        for (int c = 0; c < 20; c++) begin
            tick(1);
            if (snd_irq === 1'b1 && prev === 1'b0) rises++;
            prev = snd_irq;
        end
        tests_run++; if (rises !== 1) begin tests_failed++; $display("[TB] FAIL hold_dequeues: got %0d expected 1", rises); end
        tests_run++; if (snd_latch !== 8'hA2 || snd_irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold_latch: got latch %h irq %b expected latch a2 irq 0", snd_latch, snd_irq); end
        snd_ack = 1'b0; tick(3);
        tests_run++; if (snd_latch !== 8'hA2 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL hold_after_drop: got latch %h busy %b expected latch a2 busy 1", snd_latch, busy); end
        snd_ack = 1'b1; tick(1); snd_ack = 1'b0; tick(1);
        tests_run++; if (snd_irq !== 1'b1 || snd_latch !== 8'hA3) begin tests_failed++; $display("[TB] FAIL hold_rearm: got irq %b latch %h expected irq 1 latch a3", snd_irq, snd_latch); end
        n = 0;
        while (snd_irq === 1'b1 && n < 20) begin n++; tick(1); end
        snd_ack = 1'b1; tick(1); snd_ack = 1'b0; tick(1);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL hold_drained: got %b expected 0", busy); end
    endtask

    task automatic test_ack_in_pulse();
        int n;
        int hi;
        cpu_dout = 8'hB1; snd_wr = 1'b1; tick(1);
        cpu_dout = 8'hB2; tick(1);
        snd_wr = 1'b0; cpu_dout = 8'h00;
        n = 0;
        while (snd_irq !== 1'b1 && n < 20) begin n++; tick(1); end
        tests_run++; if (snd_latch !== 8'hB1) begin tests_failed++; $display("[TB] FAIL pulse_first: got %h expected b1", snd_latch); end
        hi = 0;
        while (snd_irq === 1'b1 && hi < 50) begin
            snd_ack = (hi == 2);
            hi++;
            tick(1);
        end
        snd_ack = 1'b0;
        tests_run++; if (hi !== 8) begin tests_failed++; $display("[TB] FAIL pulse_width: got %0d expected 8", hi); end
        tests_run++; if (snd_latch !== 8'hB1) begin tests_failed++; $display("[TB] FAIL pulse_gap_latch: got %h expected b1", snd_latch); end
        tick(1);
        tests_run++; if (snd_irq !== 1'b1 || snd_latch !== 8'hB2) begin tests_failed++; $display("[TB] FAIL pulse_next: got irq %b latch %h expected irq 1 latch b2", snd_irq, snd_latch); end
        n = 0;
        while (snd_irq === 1'b1 && n < 20) begin n++; tick(1); end
        snd_ack = 1'b1; tick(1); snd_ack = 1'b0; tick(1);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL pulse_drained: got %b expected 0", busy); end
    endtask

    task automatic test_rstb_flush();
        int n;
        for (int i = 0; i < 4; i++) begin
            cpu_dout = 8'hC1 + 8'(i); snd_wr = 1'b1; tick(1);
        end
        snd_wr = 1'b0; cpu_dout = 8'h00;
        n = 0;
        while (snd_irq === 1'b1 && n < 20) begin n++; tick(1); end
        tests_run++; if (snd_latch !== 8'hC1 || snd_irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_wait: got latch %h irq %b expected latch c1 irq 0", snd_latch, snd_irq); end
        rstb_wr = 1'b1; rstb_din = 1'b0; tick(1); rstb_wr = 1'b0;
        tests_run++; if (snd_rstb !== 1'b0 || snd_irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_lines: got rstb %b irq %b expected 0 0", snd_rstb, snd_irq); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_overflow_clr: got %b expected 0", overflow); end
        tick(1);
        tests_run++; if (busy !== 1'b0 || snd_latch !== 8'hC1) begin tests_failed++; $display("[TB] FAIL flush_idle: got busy %b latch %h expected busy 0 latch c1", busy, snd_latch); end
        cpu_dout = 8'h77; snd_wr = 1'b1; tick(1); snd_wr = 1'b0; cpu_dout = 8'h00;
        tick(10);
        tests_run++; if (snd_irq !== 1'b0 || snd_latch !== 8'hC1 || busy !== 1'b1) begin tests_failed++; $display("[TB] FAIL flush_held: got irq %b latch %h busy %b expected irq 0 latch c1 busy 1", snd_irq, snd_latch, busy); end
        rstb_wr = 1'b1; rstb_din = 1'b1; tick(1); rstb_wr = 1'b0; rstb_din = 1'b0;
        tick(1);
        tests_run++; if (snd_irq !== 1'b1 || snd_latch !== 8'h77) begin tests_failed++; $display("[TB] FAIL flush_release: got irq %b latch %h expected irq 1 latch 77", snd_irq, snd_latch); end
        n = 0;
        while (snd_irq === 1'b1 && n < 20) begin n++; tick(1); end
        snd_ack = 1'b1; tick(1); snd_ack = 1'b0; tick(1);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL flush_drained: got %b expected 0", busy); end
    endtask

`ifdef SNDCMD_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        cpu_dout = 8'hD1; snd_wr = 1'b1; tick(1);
        cpu_dout = 8'hD2; tick(1);
        snd_wr = 1'b0; cpu_dout = 8'h00;
        n = 0;
        while (snd_irq !== 1'b1 && n < 20) begin n++; tick(1); end
        n = 0;
        while (snd_irq === 1'b1 && n < 20) begin n++; tick(1); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_ovf_entry: got %b expected 0", overflow); end
        tick(15);
        tests_run++; if (overflow !== 1'b0 || snd_irq !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_early: got ovf %b irq %b expected 0 0", overflow, snd_irq); end
        tick(1);
        tests_run++; if (overflow !== 1'b1) begin tests_failed++; $display("[TB] FAIL to_ovf_set: got %b expected 1", overflow); end
        tick(1);
        tests_run++; if (snd_irq !== 1'b1 || snd_latch !== 8'hD2) begin tests_failed++; $display("[TB] FAIL to_next: got irq %b latch %h expected irq 1 latch d2", snd_irq, snd_latch); end
        n = 0;
        while (busy === 1'b1 && n < 60) begin n++; tick(1); end
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL to_drained: got %b expected 0", busy); end
    endtask
`else
    task automatic test_timeout();
        int n;
        cpu_dout = 8'hD1; snd_wr = 1'b1; tick(1); snd_wr = 1'b0; cpu_dout = 8'h00;
        n = 0;
        while (snd_irq !== 1'b1 && n < 20) begin n++; tick(1); end
        n = 0;
        while (snd_irq === 1'b1 && n < 20) begin n++; tick(1); end
        tick(10000);
        tests_run++; if (busy !== 1'b1 || snd_irq !== 1'b0 || snd_latch !== 8'hD1) begin tests_failed++; $display("[TB] FAIL wait_forever: got busy %b irq %b latch %h expected busy 1 irq 0 latch d1", busy, snd_irq, snd_latch); end
        tests_run++; if (overflow !== 1'b0) begin tests_failed++; $display("[TB] FAIL wait_no_ovf: got %b expected 0", overflow); end
        snd_ack = 1'b1; tick(1); snd_ack = 1'b0; tick(1);
        tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL wait_ack_release: got %b expected 0", busy); end
    endtask
`endif

    // Scenario sequence
    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_ack_hold();
        test_ack_in_pulse();
        test_rstb_flush();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
